// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows / InvShiftRows over LANES-byte beats with ping-pong block buffers.
// Optional macro SHIFTROWS_BYPASS_EN adds in_bypass to pass selected blocks through unpermuted.
module shift_rows_stream #(
  parameter int unsigned LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
`ifdef SHIFTROWS_BYPASS_EN
  input  logic               in_bypass,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("shift_rows_stream: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_DRAINING
  } buf_state_e;

  buf_state_e       st_q [2];
  buf_state_e       st_d [2];
  logic             mode_q [2];
  logic             mode_d [2];
  logic [7:0]       mem_q [2][16];
  logic [7:0]       mem_d [2][16];
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [3:0]       wr_base, rd_base;
  logic             in_fire, out_fire, wr_last, rd_last, rd_byp;

`ifdef SHIFTROWS_BYPASS_EN
  logic byp_q [2];
  logic byp_d [2];
  assign rd_byp = byp_q[rd_sel_q];
`else
  assign rd_byp = 1'b0;
`endif

  // Source byte for destination byte {col,row}; 2-bit column arithmetic gives the mod-4 wrap.
  function automatic logic [3:0] src_index(input logic [3:0] dst, input logic inv, input logic byp);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = dst[1:0];
    c  = dst[3:2];
    sc = byp ? c : (inv ? c - r : c + r);
    return {sc, r};
  endfunction

  assign in_ready  = (st_q[wr_sel_q] == BUF_EMPTY) || (st_q[wr_sel_q] == BUF_FILLING);
  assign out_valid = (st_q[rd_sel_q] == BUF_FULL) || (st_q[rd_sel_q] == BUF_DRAINING);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = (wr_cnt_q == LAST_BEAT);
  assign rd_last   = (rd_cnt_q == LAST_BEAT);
  assign out_last  = out_valid && rd_last;
  assign wr_base   = 4'(32'(wr_cnt_q) * LANES);
  assign rd_base   = 4'(32'(rd_cnt_q) * LANES);

  // Buffer states and pointers; fill and drain target different buffers, so both may fire.
  always_comb begin
    st_d     = st_q;
    mode_d   = mode_q;
    wr_sel_d = wr_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_sel_d = rd_sel_q;
    rd_cnt_d = rd_cnt_q;
`ifdef SHIFTROWS_BYPASS_EN
    byp_d    = byp_q;
`endif
    if (in_fire) begin
      if (wr_cnt_q == '0) begin
        mode_d[wr_sel_q] = in_inv;
`ifdef SHIFTROWS_BYPASS_EN
        byp_d[wr_sel_q]  = in_bypass;
`endif
      end
      if (wr_last) begin
        st_d[wr_sel_q] = BUF_FULL;
        wr_cnt_d       = '0;
        wr_sel_d       = ~wr_sel_q;
      end else begin
        st_d[wr_sel_q] = BUF_FILLING;
        wr_cnt_d       = wr_cnt_q + CNT_W'(1);
      end
    end
    if (out_fire) begin
      if (rd_last) begin
        st_d[rd_sel_q] = BUF_EMPTY;
        rd_cnt_d       = '0;
        rd_sel_d       = ~rd_sel_q;
      end else begin
        st_d[rd_sel_q] = BUF_DRAINING;
        rd_cnt_d       = rd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= '{BUF_EMPTY, BUF_EMPTY};
      mode_q   <= '{1'b0, 1'b0};
      wr_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_sel_q <= 1'b0;
      rd_cnt_q <= '0;
`ifdef SHIFTROWS_BYPASS_EN
      byp_q    <= '{1'b0, 1'b0};
`endif
    end else begin
      st_q     <= st_d;
      mode_q   <= mode_d;
      wr_sel_q <= wr_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_sel_q <= rd_sel_d;
      rd_cnt_q <= rd_cnt_d;
`ifdef SHIFTROWS_BYPASS_EN
      byp_q    <= byp_d;
`endif
    end
  end

  // Incoming lane j lands at byte index beat*LANES + j of the write buffer.
  always_comb begin
    mem_d = mem_q;
    if (in_fire) begin
      for (int j = 0; j < int'(LANES); j++) begin
        mem_d[wr_sel_q][wr_base + 4'(j)] = in_data[8*(int'(LANES)-j)-1 -: 8];
      end
    end
  end

  // Block storage is data only; reset leaves it untouched.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      out_data[8*(int'(LANES)-j)-1 -: 8] =
        mem_q[rd_sel_q][src_index(rd_base + 4'(j), mode_q[rd_sel_q], rd_byp)];
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: one instance per legal LANES value, all driven
// from a single cycle loop against a row-rotation reference model.
`timescale 1ns/1ps
module tb_shift_rows_stream;

  localparam int NI = 5;
  localparam int LANES_A [NI] = '{1, 2, 4, 8, 16};
  localparam logic [127:0] VEC  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FOUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_w [NI];
  logic         in_inv_w   [NI];
  logic         in_byp_w   [NI];
  logic         out_ready_w[NI];
  logic [127:0] in_data_w  [NI];
  logic         in_ready_w [NI];
  logic         out_valid_w[NI];
  logic         out_last_w [NI];
  logic [127:0] out_data_w [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned L = LANES_A[gi];
    logic             ir, ov, ol;
    logic [8*L-1:0]   od;
    shift_rows_stream #(.LANES(L)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_w[gi]),
      .in_ready (ir),
      .in_data  (in_data_w[gi][8*L-1:0]),
      .in_inv   (in_inv_w[gi]),
`ifdef SHIFTROWS_BYPASS_EN
      .in_bypass(in_byp_w[gi]),
`endif
      .out_valid(ov),
      .out_ready(out_ready_w[gi]),
      .out_data (od),
      .out_last (ol)
    );
    assign in_ready_w[gi]  = ir;
    assign out_valid_w[gi] = ov;
    assign out_last_w[gi]  = ol;
    assign out_data_w[gi]  = 128'(od);
  end

  // Reference model state: blocks waiting to be sent, blocks expected at the output.
  logic [127:0] send_blk [NI][$];
  logic [1:0]   send_md  [NI][$];   // bit0 inverse, bit1 bypass
  logic [127:0] pend_q   [NI][$];
  int           send_cnt [NI];
  int           acc_cnt  [NI];
  int           budget   [NI];
  int           acc_bytes[NI];
  int           out_cnt  [NI];
  int           out_seq  [NI];
  logic [127:0] out_col  [NI];
  int           p_in, p_out;
  bit           lit_en;
  int           n_pass = 0;
  int           n_tot  = 0;

  // ShiftRows as textbook row rotation: row r rotates left by r bytes (right for inverse).
  function automatic logic [127:0] model_perm(input logic [127:0] b, input logic [1:0] md);
    logic [127:0] o;
    logic [31:0]  w;
    logic [63:0]  ww;
    if (md[1]) return b;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) w[31-8*c -: 8] = b[127-8*(r+4*c) -: 8];
      ww = {w, w};
      if (md[0]) w = 32'(ww >> (8*r));
      else       w = ww[63-8*r -: 32];
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = w[31-8*c -: 8];
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lanes=%0d t=%0t got=%h want=%h", nm, LANES_A[i], $time, act, exp);
  endtask

  function automatic logic [127:0] beat_of(input logic [127:0] blk, input int l, input int k);
    logic [127:0] t;
    t = blk << (8 * l * k);
    return t >> (128 - 8 * l);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      send_blk[i].delete();
      send_md[i].delete();
      pend_q[i].delete();
      send_cnt[i] = 0;
      acc_cnt[i]  = 0;
      budget[i]   = 1 << 30;
      out_cnt[i]  = 0;
      out_seq[i]  = 0;
      out_col[i]  = '0;
    end
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, advance the model.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int l;
      int beats;
      bit exp_valid;
      bit exp_last;
      l         = LANES_A[i];
      beats     = 16 / l;
      exp_valid = pend_q[i].size() > 0;
      exp_last  = exp_valid && (out_cnt[i] == beats - 1);
      chk("out_valid", i, 128'(out_valid_w[i]), 128'(exp_valid));
      chk("in_ready", i, 128'(in_ready_w[i]), 128'(acc_cnt[i] > 0 || pend_q[i].size() < 2));
      chk("out_last", i, 128'(out_last_w[i]), 128'(exp_last));
      if (exp_valid) chk("out_data", i, out_data_w[i], beat_of(pend_q[i][0], l, out_cnt[i]));

      in_valid_w[i] = send_blk[i].size() > 0 && budget[i] > 0 && ($urandom_range(99) < p_in);
      in_inv_w[i]   = 1'($urandom);
      in_byp_w[i]   = 1'($urandom);
      in_data_w[i]  = beat_of({$urandom, $urandom, $urandom, $urandom}, l, 0);
      if (in_valid_w[i]) begin
        in_data_w[i] = beat_of(send_blk[i][0], l, send_cnt[i]);
        if (send_cnt[i] == 0) begin
          in_inv_w[i] = send_md[i][0][0];
          in_byp_w[i] = send_md[i][0][1];
        end
      end
      out_ready_w[i] = $urandom_range(99) < p_out;

      if (in_valid_w[i] && in_ready_w[i]) begin
        budget[i]--;
        acc_bytes[i] += l;
        send_cnt[i]++;
        acc_cnt[i] = send_cnt[i];
        if (send_cnt[i] == beats) begin
          pend_q[i].push_back(model_perm(send_blk[i][0], send_md[i][0]));
          void'(send_blk[i].pop_front());
          void'(send_md[i].pop_front());
          send_cnt[i] = 0;
          acc_cnt[i]  = 0;
        end
      end
      if (out_valid_w[i] && out_ready_w[i] && exp_valid) begin
        out_col[i] = (out_col[i] << (8 * l)) | out_data_w[i];
        out_cnt[i]++;
        if (out_cnt[i] == beats) begin
          if (lit_en && out_seq[i] < 3)
            chk("literal_block", i, out_col[i], (out_seq[i] == 0) ? FOUT : VEC);
          void'(pend_q[i].pop_front());
          out_cnt[i] = 0;
          out_seq[i]++;
        end
      end
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++)
      if (send_blk[i].size() != 0 || pend_q[i].size() != 0 || acc_cnt[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_phase(input int max_cycles);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cycles) begin
      step();
      n++;
      done = all_idle();
    end
    chk("phase_done", 0, 128'(done), 128'(1));
  endtask

  task automatic queue_all(input logic [127:0] blk, input logic [1:0] md);
    for (int i = 0; i < NI; i++) begin
      send_blk[i].push_back(blk);
      send_md[i].push_back(md);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_valid_w[i]  = 1'b0;
      in_inv_w[i]    = 1'b0;
      in_byp_w[i]    = 1'b0;
      out_ready_w[i] = 1'b0;
      in_data_w[i]   = '0;
      acc_bytes[i]   = 0;
    end
    clear_model();
    p_in   = 0;
    p_out  = 0;
    lit_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known vectors: forward block, then its output fed back through the inverse.
    lit_en = 1'b1;
    p_in   = 100;
    p_out  = 100;
    queue_all(VEC, 2'b00);
    queue_all(FOUT, 2'b01);
`ifdef SHIFTROWS_BYPASS_EN
    queue_all(VEC, 2'b10);
`endif
    run_phase(200);
    lit_en = 1'b0;

    // Downstream stalled: exactly two blocks are absorbed, then in_ready drops.
    for (int i = 0; i < NI; i++) acc_bytes[i] = 0;
    p_out = 0;
    for (int b = 0; b < 3; b++) queue_all({$urandom, $urandom, $urandom, $urandom}, 2'(b & 1));
    repeat (40) step();
    for (int i = 0; i < NI; i++) chk("stall_accept_bytes", i, 128'(acc_bytes[i]), 128'(32));
    p_out = 100;
    run_phase(200);

    // Random data, modes and handshake throttling on both sides.
    p_in  = 70;
    p_out = 60;
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < NI; i++) begin
        logic [1:0] md;
        md = 2'($urandom);
`ifndef SHIFTROWS_BYPASS_EN
        md[1] = 1'b0;
`endif
        send_blk[i].push_back({$urandom, $urandom, $urandom, $urandom});
        send_md[i].push_back(md);
      end
    end
    run_phase(3000);

    // Partial block, asynchronous reset, then a fresh block must come out alone.
    p_in  = 100;
    p_out = 0;
    queue_all(VEC, 2'b01);
    for (int i = 0; i < NI; i++) budget[i] = (7 / LANES_A[i] == 0) ? 1 : 7 / LANES_A[i];
    repeat (10) step();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < NI; i++) in_valid_w[i] = 1'b0;
    lit_en = 1'b1;
    p_out  = 100;
    queue_all(VEC, 2'b00);
    run_phase(200);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
